// File: rtl/int_ctrl_mc.sv
// Multi-pin interrupt controller for the 32 kHz always-on domain.
// Rising edges on event_flags set sticky status bits. Per-pin routing masks
// feed NOUT independent pin sequencers. Each sequencer supports polarity,
// pulse/level mode, pulse width, cold hold-off and deferral until frame end.
module int_ctrl_mc #(
  parameter int unsigned NW   = 16,
  parameter int unsigned NOUT = 2,
  parameter int unsigned WW   = 11,
  parameter int unsigned CW   = 6,
  parameter int unsigned CDIV = 32
) (
  input  logic                 clk_32k,
  input  logic                 rst_n,
  input  logic [NW-1:0]        event_flags,
  input  logic [NW-1:0]        event_clear,
  input  logic [NOUT*NW-1:0]   events_route,
  input  logic [NOUT-1:0]      rg_int_low_en,
  input  logic [NOUT-1:0]      rg_int_level_en,
  input  logic [NOUT*WW-1:0]   rg_int_width,
  input  logic [NOUT*CW-1:0]   rg_cold_time,
  input  logic [NOUT-1:0]      int_after_frame,
  input  logic                 frame_on,
  output logic [NW-1:0]        events,
  output logic [NOUT-1:0]      int_pending,
  output logic [NOUT-1:0]      int_out
);

  // Cold counter holds up to 2^CW ms worth of clk_32k cycles.
  localparam int unsigned CCW = CW + $clog2(CDIV);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StAssert = 2'd2;
  localparam logic [1:0] StCold   = 2'd3;

  logic [NW-1:0] r_flag;
  logic [NW-1:0] r_set;
  logic [NW-1:0] r_events;
  logic [NW-1:0] w_set;
  logic [NW-1:0] w_events_d;

  assign w_set      = event_flags & ~r_flag;
  // Set wins over a clear in the same cycle.
  assign w_events_d = w_set | (r_events & ~event_clear);
  assign events     = r_events;

  // Edge detector, sticky status and a one-cycle delayed copy of the set pulses.
  // Pins react to r_set so status is always visible one cycle before a pin moves.
  always_ff @(posedge clk_32k or negedge rst_n) begin
    if (!rst_n) begin
      r_flag   <= '0;
      r_set    <= '0;
      r_events <= '0;
    end else begin
      r_flag   <= event_flags;
      r_set    <= w_set;
      r_events <= w_events_d;
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_pin
    logic [NW-1:0]  w_route;
    logic [WW-1:0]  w_width;
    logic [CW-1:0]  w_cold;
    logic [CCW-1:0] w_cold_load;
    logic           w_level;
    logic           w_pend;
    logic           w_new;
    logic           w_go;

    logic [1:0]     r_state;
    logic [1:0]     w_state_d;
    logic           r_req;
    logic           w_req_d;
    logic [WW-1:0]  r_wcnt;
    logic [WW-1:0]  w_wcnt_d;
    logic [CCW-1:0] r_ccnt;
    logic [CCW-1:0] w_ccnt_d;

    assign w_route     = events_route[k*NW +: NW];
    assign w_width     = rg_int_width[k*WW +: WW];
    assign w_cold      = rg_cold_time[k*CW +: CW];
    assign w_cold_load = CCW'((32'(w_cold) + 32'd1) * CDIV - 32'd1);
    assign w_level     = rg_int_level_en[k];
    assign w_pend      = |(r_events & w_route);
    assign w_new       = |(r_set & w_route);
    assign w_go        = w_level ? w_pend : (r_req | w_new);

    assign int_pending[k] = w_pend;
    assign int_out[k]     = (r_state == StAssert) ^ rg_int_low_en[k];

    // Pin sequencer next state, request latch and counter loads.
    always_comb begin
      w_state_d = r_state;
      w_req_d   = r_req | w_new;
      w_wcnt_d  = r_wcnt;
      w_ccnt_d  = r_ccnt;
      case (r_state)
        StIdle: begin
          if (w_go) begin
            w_state_d = (int_after_frame[k] && frame_on) ? StWait : StAssert;
          end
        end
        StWait: begin
          if (!frame_on) begin
            w_state_d = (!w_level || w_pend) ? StAssert : StIdle;
          end
        end
        StAssert: begin
          if (w_level) begin
            if (!w_pend) w_state_d = StCold;
          end else if (r_wcnt == '0) begin
            w_state_d = StCold;
          end else begin
            w_wcnt_d = r_wcnt - WW'(1);
          end
        end
        StCold: begin
          if (r_ccnt == '0) begin
            w_state_d = StIdle;
          end else begin
            w_ccnt_d = r_ccnt - CCW'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
      // Width is sampled and the request consumed only on entry to ASSERT.
      if (w_state_d == StAssert && r_state != StAssert) begin
        w_req_d  = 1'b0;
        w_wcnt_d = w_width;
      end
      if (w_state_d == StCold && r_state != StCold) begin
        w_ccnt_d = w_cold_load;
      end
    end

    // Pin sequencer state registers.
    always_ff @(posedge clk_32k or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= StIdle;
        r_req   <= 1'b0;
        r_wcnt  <= '0;
        r_ccnt  <= '0;
      end else begin
        r_state <= w_state_d;
        r_req   <= w_req_d;
        r_wcnt  <= w_wcnt_d;
        r_ccnt  <= w_ccnt_d;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl_mc.sv
// Self-checking bench for int_ctrl_mc: directed scenarios plus a randomized
// run compared every cycle against a duration-based behavioural model.
module tb_int_ctrl_mc;

  localparam int NW   = 16;
  localparam int NOUT = 2;
  localparam int WW   = 11;
  localparam int CW   = 6;
  localparam int CDIV = 32;

  localparam int PIdle = 0;
  localparam int PWait = 1;
  localparam int POn   = 2;
  localparam int PCold = 3;

  logic                 clk_32k = 1'b0;
  logic                 rst_n;
  logic [NW-1:0]        event_flags;
  logic [NW-1:0]        event_clear;
  logic [NOUT*NW-1:0]   events_route;
  logic [NOUT-1:0]      rg_int_low_en;
  logic [NOUT-1:0]      rg_int_level_en;
  logic [NOUT*WW-1:0]   rg_int_width;
  logic [NOUT*CW-1:0]   rg_cold_time;
  logic [NOUT-1:0]      int_after_frame;
  logic                 frame_on;
  logic [NW-1:0]        events;
  logic [NOUT-1:0]      int_pending;
  logic [NOUT-1:0]      int_out;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: status vector plus per-pin phase and remaining duration.
  logic [NW-1:0] m_ev;
  logic [NW-1:0] m_prev;
  logic [NW-1:0] m_setd;
  int            m_phase [NOUT];
  int            m_left  [NOUT];
  bit            m_req   [NOUT];

  int nh, first, start2;
  logic prev;

  int_ctrl_mc #(
    .NW(NW), .NOUT(NOUT), .WW(WW), .CW(CW), .CDIV(CDIV)
  ) dut (
    .clk_32k        (clk_32k),
    .rst_n          (rst_n),
    .event_flags    (event_flags),
    .event_clear    (event_clear),
    .events_route   (events_route),
    .rg_int_low_en  (rg_int_low_en),
    .rg_int_level_en(rg_int_level_en),
    .rg_int_width   (rg_int_width),
    .rg_cold_time   (rg_cold_time),
    .int_after_frame(int_after_frame),
    .frame_on       (frame_on),
    .events         (events),
    .int_pending    (int_pending),
    .int_out        (int_out)
  );

  always #5 clk_32k = ~clk_32k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ev   = '0;
    m_prev = '0;
    m_setd = '0;
    for (int k = 0; k < NOUT; k++) begin
      m_phase[k] = PIdle;
      m_left[k]  = 0;
      m_req[k]   = 1'b0;
    end
  endtask

  function automatic logic [NOUT-1:0] m_pend();
    logic [NOUT-1:0] r;
    r = '0;
    for (int k = 0; k < NOUT; k++) r[k] = |(m_ev & events_route[k*NW +: NW]);
    return r;
  endfunction

  function automatic logic [NOUT-1:0] m_out();
    logic [NOUT-1:0] r;
    r = '0;
    for (int k = 0; k < NOUT; k++) r[k] = (m_phase[k] == POn) ^ rg_int_low_en[k];
    return r;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    logic [NW-1:0]   set_v;
    logic [NOUT-1:0] pend;
    logic            nw;
    logic            lvl;
    logic            go;
    logic            enter_on;
    int              cold_len;
    set_v = event_flags & ~m_prev;
    pend  = m_pend();
    for (int k = 0; k < NOUT; k++) begin
      nw       = |(m_setd & events_route[k*NW +: NW]);
      lvl      = rg_int_level_en[k];
      go       = lvl ? pend[k] : (m_req[k] | nw);
      enter_on = 1'b0;
      cold_len = (int'(rg_cold_time[k*CW +: CW]) + 1) * CDIV;
      case (m_phase[k])
        PIdle: if (go) begin
          if (int_after_frame[k] && frame_on) m_phase[k] = PWait;
          else enter_on = 1'b1;
        end
        PWait: if (!frame_on) begin
          if (!lvl || pend[k]) enter_on = 1'b1;
          else m_phase[k] = PIdle;
        end
        POn: begin
          if (lvl) begin
            if (!pend[k]) begin
              m_phase[k] = PCold;
              m_left[k]  = cold_len;
            end
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_phase[k] = PCold;
              m_left[k]  = cold_len;
            end
          end
        end
        default: begin
          m_left[k]--;
          if (m_left[k] == 0) m_phase[k] = PIdle;
        end
      endcase
      if (enter_on) begin
        m_phase[k] = POn;
        m_left[k]  = int'(rg_int_width[k*WW +: WW]) + 1;
        m_req[k]   = 1'b0;
      end else begin
        m_req[k] = m_req[k] | nw;
      end
    end
    m_ev   = set_v | (m_ev & ~event_clear);
    m_prev = event_flags;
    m_setd = set_v;
  endtask

  task automatic tick();
    @(posedge clk_32k);
    model_step();
    #1;
    check("events", 32'(events), 32'(m_ev));
    check("int_pending", 32'(int_pending), 32'(m_pend()));
    check("int_out", 32'(int_out), 32'(m_out()));
  endtask

  // Asynchronous reset away from the clock edge; outputs must fall back at once.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_events"}, 32'(events), 32'd0);
    check({tag, "_out"}, 32'(int_out), 32'(rg_int_low_en));
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    event_flags     = '0;
    event_clear     = '0;
    events_route    = '0;
    rg_int_low_en   = 2'b10;
    rg_int_level_en = '0;
    rg_int_width    = '0;
    rg_cold_time    = '0;
    int_after_frame = '0;
    frame_on        = 1'b0;
    model_reset();
    #2;
    check("rst_events", 32'(events), 32'd0);
    check("rst_out", 32'(int_out), 32'h2);
    check("rst_pending", 32'(int_pending), 32'd0);
    #10;
    rst_n = 1'b1;

    // Pin0 pulse width 3, cold 0 on bit3; pin1 level, cold 1 on bit5.
    events_route          = '0;
    events_route[3]       = 1'b1;
    events_route[NW+5]    = 1'b1;
    rg_int_level_en       = 2'b10;
    rg_int_width          = {11'd0, 11'd3};
    rg_cold_time          = {6'd1, 6'd0};
    tick();
    event_flags[3] = 1'b1;
    nh = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) check("t1_ev3", 32'(events[3]), 32'd1);
      if (int_out[0]) begin
        nh++;
        if (first == 0) first = i;
      end
    end
    check("t1_width", nh, 4);
    check("t1_start", first, 2);
    event_flags[3] = 1'b0;
    tick();

    // Level pin held until clear, then 64-cycle hold-off.
    event_flags[5] = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    check("t2_active", 32'(int_out[1]), 32'd0);
    event_flags[5] = 1'b0;
    event_clear[5] = 1'b1;
    tick();
    event_clear = '0;
    check("t2_hold", 32'(int_out[1]), 32'd0);
    tick();
    check("t2_drop", 32'(int_out[1]), 32'd1);
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 2) event_flags[5] = 1'b1;
      tick();
      if (!int_out[1] && first == 0) first = i;
    end
    check("t2_cold", first, 65);
    event_clear[5] = 1'b1;
    tick();
    event_clear    = '0;
    event_flags[5] = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    check("t2_idle", 32'(int_out[1]), 32'd1);

    // Same-cycle set and clear: set wins; a later clear removes it.
    event_flags[7] = 1'b1;
    event_clear[7] = 1'b1;
    tick();
    check("t3_set_wins", 32'(events[7]), 32'd1);
    tick();
    check("t3_cleared", 32'(events[7]), 32'd0);
    event_clear    = '0;
    event_flags[7] = 1'b0;
    tick();

    // Deferral until frame end.
    int_after_frame = 2'b01;
    frame_on        = 1'b1;
    event_flags[3]  = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    check("t4_wait", 32'(int_out[0]), 32'd0);
    frame_on = 1'b0;
    tick();
    check("t4_go", 32'(int_out[0]), 32'd1);
    event_flags[3]  = 1'b0;
    int_after_frame = '0;
    for (int i = 0; i < 45; i++) tick();

    // Second event during cold yields exactly one extra pulse after cold.
    nh = 0; start2 = 0; first = 0; prev = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 1)  event_flags[3] = 1'b1;
      if (i == 10) event_flags[3] = 1'b0;
      if (i == 12) event_flags[3] = 1'b1;
      tick();
      if (int_out[0]) nh++;
      if (int_out[0] && !prev) begin
        if (first == 0) first = i;
        else if (start2 == 0) start2 = i;
      end
      prev = int_out[0];
    end
    check("t5_highs", nh, 8);
    check("t5_start2", start2, 39);
    event_flags[3] = 1'b0;
    tick();

    // Asynchronous reset mid-pulse.
    event_flags[3] = 1'b1;
    tick();
    tick();
    tick();
    check("t6_pre", 32'(int_out[0]), 32'd1);
    event_flags = '0;
    do_reset("t6_rst");
    tick();

    // Minimum width and maximum cold time.
    rg_int_width = {11'd0, 11'd0};
    rg_cold_time = {6'd1, 6'd63};
    nh = 0; start2 = 0; first = 0; prev = 1'b0;
    for (int i = 1; i <= 2060; i++) begin
      if (i == 1)  event_flags[3] = 1'b1;
      if (i == 20) event_flags[3] = 1'b0;
      if (i == 22) event_flags[3] = 1'b1;
      tick();
      if (int_out[0]) nh++;
      if (int_out[0] && !prev) begin
        if (first == 0) first = i;
        else if (start2 == 0) start2 = i;
      end
      prev = int_out[0];
    end
    check("t7_highs", nh, 2);
    check("t7_start2", start2, 2052);
    event_flags = '0;
    tick();
    do_reset("t7_rst");

    // Randomized run with periodic reconfiguration mid-operation.
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        events_route    = $urandom & $urandom;
        rg_int_level_en = 2'($urandom);
        rg_int_low_en   = 2'($urandom);
        int_after_frame = 2'($urandom);
        rg_int_width    = {11'($urandom_range(0, 6)), 11'($urandom_range(0, 6))};
        rg_cold_time    = {6'($urandom_range(0, 1)), 6'($urandom_range(0, 1))};
      end
      event_flags = event_flags ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      event_clear = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : '0;
      if ($urandom_range(0, 15) == 0) frame_on = ~frame_on;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
